// File: rtl/fp32_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp32_pkg : shared FP32 format constants and converter state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package fp32_pkg;

   localparam int FP32_BIAS    = 127;
   localparam int FP32_EXP_W   = 8;
   localparam int FP32_MANT_W  = 23;
   localparam int I2F_EXP_BASE = 158;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      PACK = 2'd2,
      DONE = 2'd3
   } i2f_state_e;

endpackage
`default_nettype wire

// File: rtl/fp32_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp32_pack : packs {sign, exp, normalised magnitude} into FP32, truncating
// Revision  : 1.0
// ---------------------------------------------------------------------------
module fp32_pack
   import fp32_pkg::*;
(
   input  logic                  i_sign,
   input  logic [FP32_EXP_W-1:0] i_exp,
   input  logic [30:0]           i_mag,
   output logic [31:0]           o_data,
   output logic                  o_inexact
);

   // The hidden leading one (mag[31]) is implied, so only bits below it are packed.
   assign o_data    = {i_sign, i_exp, i_mag[30:30-FP32_MANT_W+1]};
   assign o_inexact = |i_mag[30-FP32_MANT_W:0];

endmodule
`default_nettype wire

// File: rtl/int_to_float_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_to_float_converter : iterative 32-bit integer to FP32, round-toward-zero
// Revision               : 1.0
// ---------------------------------------------------------------------------
module int_to_float_converter
   import fp32_pkg::*;
#(
   parameter int SIGNED_IN = 1,
   parameter int EXP_BASE  = I2F_EXP_BASE
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_inexact
);

   localparam logic [FP32_EXP_W-1:0] c_EXP_BASE = EXP_BASE[FP32_EXP_W-1:0];

   i2f_state_e              r_state;
   i2f_state_e              w_state_nxt;
   logic                    r_sign;
   logic [31:0]             r_mag;
   logic [FP32_EXP_W-1:0]   r_exp_cnt;
   logic [31:0]             r_out_data;
   logic                    r_out_inexact;

   logic                    w_sign;
   logic [31:0]             w_mag;
   logic                    w_mag_zero;
   logic [31:0]             w_pack_data;
   logic                    w_pack_inexact;

   assign w_sign     = (SIGNED_IN != 0) & in_data[31];
   assign w_mag      = w_sign ? (~in_data + 32'd1) : in_data;
   assign w_mag_zero = (w_mag == 32'd0);

   fp32_pack u_pack (
      .i_sign    (r_sign),
      .i_exp     (r_exp_cnt),
      .i_mag     (r_mag[30:0]),
      .o_data    (w_pack_data),
      .o_inexact (w_pack_inexact)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (in_valid) w_state_nxt = w_mag_zero ? DONE : NORM;
         NORM: if (r_mag[31]) w_state_nxt = PACK;
         PACK: w_state_nxt = DONE;
         DONE: if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Datapath: capture on acceptance, shift until the leading one reaches bit 31.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign        <= 1'b0;
         r_mag         <= 32'd0;
         r_exp_cnt     <= '0;
         r_out_data    <= 32'd0;
         r_out_inexact <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sign    <= w_sign;
                  r_mag     <= w_mag;
                  r_exp_cnt <= c_EXP_BASE;
                  if (w_mag_zero) begin
                     r_out_data    <= 32'd0;
                     r_out_inexact <= 1'b0;
                  end
               end
            end
            NORM: begin
               if (!r_mag[31]) begin
                  r_mag     <= {r_mag[30:0], 1'b0};
                  r_exp_cnt <= r_exp_cnt - 1'b1;
               end
            end
            PACK: begin
               r_out_data    <= w_pack_data;
               r_out_inexact <= w_pack_inexact;
            end
            default: begin
            end
         endcase
      end
   end

   assign out_data    = r_out_data;
   assign out_inexact = r_out_inexact;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_int_to_float_converter : directed vectors for signed and unsigned builds
// Revision                  : 1.0
// ---------------------------------------------------------------------------
module tb_int_to_float_converter;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        out_ready;
   logic        in_valid_s, in_ready_s, out_valid_s, out_inexact_s;
   logic        in_valid_u, in_ready_u, out_valid_u, out_inexact_u;
   logic [31:0] out_data_s, out_data_u;

   logic        sel_u;
   logic        w_ir, w_ov, w_oi;
   logic [31:0] w_od;

   int n_checks;
   int n_err;

   typedef struct {
      logic        uns;
      logic [31:0] din;
      logic [31:0] exp_data;
      logic        exp_inex;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];

   int_to_float_converter #(.SIGNED_IN(1)) u_dut_s (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_inexact(out_inexact_s)
   );

   int_to_float_converter #(.SIGNED_IN(0)) u_dut_u (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data),
      .out_valid(out_valid_u), .out_ready(out_ready),
      .out_data(out_data_u), .out_inexact(out_inexact_u)
   );

   assign w_ir = sel_u ? in_ready_u    : in_ready_s;
   assign w_ov = sel_u ? out_valid_u   : out_valid_s;
   assign w_oi = sel_u ? out_inexact_u : out_inexact_s;
   assign w_od = sel_u ? out_data_u    : out_data_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Launch one conversion and return edges from acceptance to out_valid (-1 on timeout).
   task automatic run_vec(input logic uns, input logic [31:0] d, output int lat);
      sel_u = uns;
      @(negedge clk);
      in_data = d;
      if (uns) in_valid_u = 1'b1; else in_valid_s = 1'b1;
      chk("in_ready_before_accept", {31'd0, w_ir}, 32'd1);
      @(posedge clk);
      #1;
      in_valid_s = 1'b0;
      in_valid_u = 1'b0;
      lat = -1;
      for (int n = 0; n <= 40; n++) begin
         if (w_ov) begin
            lat = n;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lat;
      int seen;
      n_checks   = 0;
      n_err      = 0;
      rst        = 1'b1;
      in_data    = 32'd0;
      in_valid_s = 1'b0;
      in_valid_u = 1'b0;
      out_ready  = 1'b1;
      sel_u      = 1'b0;

      vecs[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 1'b0, 33};
      vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 33};
      vecs[2]  = '{1'b0, 32'h00000007, 32'h40E00000, 1'b0, 31};
      vecs[3]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 0};
      vecs[4]  = '{1'b0, 32'h80000000, 32'hCF000000, 1'b0, 2};
      vecs[5]  = '{1'b1, 32'h80000000, 32'h4F000000, 1'b0, 2};
      vecs[6]  = '{1'b0, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1, 3};
      vecs[7]  = '{1'b0, 32'h00000100, 32'h43800000, 1'b0, 25};
      vecs[8]  = '{1'b0, 32'hFFFFFFF9, 32'hC0E00000, 1'b0, 31};
      vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1, 2};
      vecs[10] = '{1'b0, 32'h12345679, 32'h4D91A2B3, 1'b1, 5};
      vecs[11] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_in_ready",    {31'd0, in_ready_s},    32'd1);
      chk("rst_out_valid",   {31'd0, out_valid_s},   32'd0);
      chk("rst_out_data",    out_data_s,             32'd0);
      chk("rst_out_inexact", {31'd0, out_inexact_s}, 32'd0);
      chk("rst_u_in_ready",  {31'd0, in_ready_u},    32'd1);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i].uns, vecs[i].din, lat);
         chk($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
         if (lat < 0) begin
            do_reset();
         end else begin
            chk($sformatf("data[%0d]", i), w_od, vecs[i].exp_data);
            chk($sformatf("inexact[%0d]", i), {31'd0, w_oi}, {31'd0, vecs[i].exp_inex});
            chk($sformatf("in_ready_done[%0d]", i), {31'd0, w_ir}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("valid_cleared[%0d]", i), {31'd0, w_ov}, 32'd0);
            chk($sformatf("idle_ready[%0d]", i), {31'd0, w_ir}, 32'd1);
         end
      end

      // Backpressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      run_vec(1'b0, 32'h00000007, lat);
      chk("bp_latency", 32'(lat), 32'd31);
      for (int c = 0; c < 5; c++) begin
         chk("bp_data_stable", out_data_s, 32'h40E00000);
         chk("bp_valid_held", {31'd0, out_valid_s}, 32'd1);
         chk("bp_in_ready_low", {31'd0, in_ready_s}, 32'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", {31'd0, out_valid_s}, 32'd0);

      // Reset in the middle of normalisation discards the conversion.
      sel_u = 1'b0;
      @(negedge clk);
      in_data    = 32'h00000001;
      in_valid_s = 1'b1;
      @(posedge clk);
      #1;
      in_valid_s = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("norm_busy", {31'd0, in_ready_s}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready", {31'd0, in_ready_s}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid_s}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (out_valid_s) seen++;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);

      // Reset and in_valid together: nothing is captured.
      @(negedge clk);
      rst        = 1'b1;
      in_valid_s = 1'b1;
      in_data    = 32'h00000000;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      in_valid_s = 1'b0;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         if (out_valid_s) seen++;
         @(posedge clk);
         #1;
      end
      chk("rst_wins_no_result", 32'(seen), 32'd0);
      chk("rst_wins_in_ready", {31'd0, in_ready_s}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
